// File: rtl/pio_osr_autopull.sv
// PIO output shift register: holds one TX-FIFO word and shifts 1..WIDTH bits per OUT,
// with blocking/non-blocking PULL, MOV load and threshold-driven autopull refill.
module pio_osr_autopull #(
    parameter int WIDTH = 32,
    localparam int NW = $clog2(WIDTH),
    localparam int CW = NW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             penable,
    input  logic             dir,
    input  logic             autopull,
    input  logic [NW-1:0]    pull_thresh,
    input  logic             out_req,
    input  logic [NW-1:0]    out_count,
    input  logic             pull_req,
    input  logic             pull_block,
    input  logic             mov_load,
    input  logic [WIDTH-1:0] mov_data,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_valid,
    output logic             fifo_ready,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    output logic             stall,
    output logic [CW-1:0]    shift_count
);

    localparam logic [CW-1:0]    FULL_CNT = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ONES     = '1;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;

    logic [CW-1:0]    thresh;
    logic [CW-1:0]    n_bits;
    logic [CW:0]      count_sum;
    logic [CW-1:0]    count_after_out;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_shifted;

    always_comb begin
        thresh          = (pull_thresh == '0) ? FULL_CNT : {1'b0, pull_thresh};
        n_bits          = (out_count == '0) ? FULL_CNT : {1'b0, out_count};
        // Widened sum so count + n saturates at WIDTH instead of wrapping.
        count_sum       = {1'b0, count_q} + {1'b0, n_bits};
        count_after_out = (count_sum > {1'b0, FULL_CNT}) ? FULL_CNT : count_sum[CW-1:0];
        out_data        = dir ? (shift_q & (ONES >> (FULL_CNT - n_bits)))
                              : (shift_q >> (FULL_CNT - n_bits));
        out_shifted     = dir ? (shift_q >> n_bits) : (shift_q << n_bits);
    end

    always_comb begin
        shift_d    = shift_q;
        count_d    = count_q;
        fifo_ready = 1'b0;
        dout       = '0;
        out_valid  = 1'b0;
        stall      = 1'b0;

        if (!reset && penable) begin
            if (mov_load) begin
                shift_d = mov_data;
                count_d = '0;
            end else if (pull_req) begin
                // With autopull on, a PULL before the threshold is reached does nothing.
                if (!(autopull && (count_q < thresh))) begin
                    if (fifo_valid) begin
                        shift_d    = fifo_data;
                        count_d    = '0;
                        fifo_ready = 1'b1;
                    end else if (pull_block) begin
                        stall = 1'b1;
                    end else begin
                        count_d = '0;
                    end
                end
            end else if (out_req) begin
                if (autopull && (count_q >= thresh)) begin
                    stall = 1'b1;
                    if (fifo_valid) begin
                        shift_d    = fifo_data;
                        count_d    = '0;
                        fifo_ready = 1'b1;
                    end
                end else begin
                    dout      = out_data;
                    out_valid = 1'b1;
                    shift_d   = out_shifted;
                    count_d   = count_after_out;
                    if (autopull && fifo_valid && (count_after_out >= thresh)) begin
                        shift_d    = fifo_data;
                        count_d    = '0;
                        fifo_ready = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            count_q <= FULL_CNT;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign shift_count = count_q;

endmodule

// File: tb/tb_pio_osr_autopull.sv
// Self-checking bench for pio_osr_autopull: directed test-plan sequence followed by
// randomized traffic, all compared against a bit-arithmetic reference model.
module tb_pio_osr_autopull;

    localparam int WIDTH = 32;
    localparam int NW    = 5;
    localparam int CW    = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             penable;
    logic             dir;
    logic             autopull;
    logic [NW-1:0]    pull_thresh;
    logic             out_req;
    logic [NW-1:0]    out_count;
    logic             pull_req;
    logic             pull_block;
    logic             mov_load;
    logic [WIDTH-1:0] mov_data;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_valid;
    logic             fifo_ready;
    logic [WIDTH-1:0] dout;
    logic             out_valid;
    logic             stall;
    logic [CW-1:0]    shift_count;

    int check_cnt = 0;
    int err_cnt   = 0;

    // Reference model state: register contents and number of bits consumed.
    logic [31:0] m_reg = 32'h0;
    int          m_cnt = 32;

    logic [31:0] obs_dout;
    logic        obs_ready, obs_valid, obs_stall;

    pio_osr_autopull #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .penable(penable), .dir(dir), .autopull(autopull),
        .pull_thresh(pull_thresh), .out_req(out_req), .out_count(out_count),
        .pull_req(pull_req), .pull_block(pull_block), .mov_load(mov_load),
        .mov_data(mov_data), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
        .fifo_ready(fifo_ready), .dout(dout), .out_valid(out_valid), .stall(stall),
        .shift_count(shift_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelEval(output logic e_ready, output logic e_valid, output logic e_stall,
                             output logic [31:0] e_dout, output logic [31:0] n_reg, output int n_cnt);
        longint unsigned r;
        int t, n;
        r = 64'(m_reg);
        t = (pull_thresh == 0) ? 32 : int'(pull_thresh);
        n = (out_count == 0) ? 32 : int'(out_count);
        e_ready = 0; e_valid = 0; e_stall = 0; e_dout = 0;
        n_reg = m_reg; n_cnt = m_cnt;
        if (reset) begin
            n_reg = 0; n_cnt = 32;
        end else if (penable) begin
            if (mov_load) begin
                n_reg = mov_data; n_cnt = 0;
            end else if (pull_req) begin
                if (autopull && m_cnt < t) begin
                    // ignored
                end else if (fifo_valid) begin
                    n_reg = fifo_data; n_cnt = 0; e_ready = 1;
                end else if (pull_block) begin
                    e_stall = 1;
                end else begin
                    n_cnt = 0;
                end
            end else if (out_req) begin
                if (autopull && m_cnt >= t) begin
                    e_stall = 1;
                    if (fifo_valid) begin
                        n_reg = fifo_data; n_cnt = 0; e_ready = 1;
                    end
                end else begin
                    if (dir) begin
                        e_dout = 32'(r % (64'd1 << n));
                        n_reg  = 32'(r >> n);
                    end else begin
                        e_dout = 32'(r >> (32 - n));
                        n_reg  = 32'((r << n) & 64'hFFFF_FFFF);
                    end
                    e_valid = 1;
                    n_cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
                    if (autopull && fifo_valid && n_cnt >= t) begin
                        n_reg = fifo_data; n_cnt = 0; e_ready = 1;
                    end
                end
            end
        end
    endtask

    // One clock cycle: inputs are already driven; sample mid-cycle, then check the new count.
    task automatic applyStimulus();
        logic        e_ready, e_valid, e_stall;
        logic [31:0] e_dout, n_reg;
        int          n_cnt;
        @(negedge clk);
        modelEval(e_ready, e_valid, e_stall, e_dout, n_reg, n_cnt);
        obs_dout = dout; obs_ready = fifo_ready; obs_valid = out_valid; obs_stall = stall;
        checkOutput("fifo_ready", 64'(fifo_ready), 64'(e_ready));
        checkOutput("out_valid", 64'(out_valid), 64'(e_valid));
        checkOutput("stall", 64'(stall), 64'(e_stall));
        checkOutput("dout", 64'(dout), 64'(e_dout));
        @(posedge clk);
        #1;
        m_reg = n_reg;
        m_cnt = n_cnt;
        checkOutput("shift_count", 64'(shift_count), 64'(m_cnt));
    endtask

    task automatic idleInputs();
        reset = 0; penable = 1; dir = 1; autopull = 0; pull_thresh = 0;
        out_req = 0; out_count = 0; pull_req = 0; pull_block = 0;
        mov_load = 0; mov_data = 0; fifo_data = 0; fifo_valid = 0;
    endtask

    task automatic doOut(input logic d, input int cnt);
        out_req = 1; dir = d; out_count = NW'(cnt);
        applyStimulus();
        out_req = 0;
    endtask

    initial begin
        idleInputs();
        reset = 1;
        applyStimulus();
        checkOutput("tp_reset_count", 64'(shift_count), 64'd32);
        reset = 0;

        // PULL then two LSB-first OUT 8
        pull_req = 1; fifo_valid = 1; fifo_data = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("tp_pull_ready", 64'(obs_ready), 64'd1);
        pull_req = 0; fifo_valid = 0;
        doOut(1, 8);
        checkOutput("tp_out8_a", 64'(obs_dout), 64'hEF);
        doOut(1, 8);
        checkOutput("tp_out8_b", 64'(obs_dout), 64'hBE);
        checkOutput("tp_count16", 64'(shift_count), 64'd16);

        // MOV then MSB-first OUTs down to empty, then an OUT on empty without autopull
        mov_load = 1; mov_data = 32'h80000001;
        applyStimulus();
        mov_load = 0;
        doOut(0, 1);
        checkOutput("tp_msb_bit", 64'(obs_dout), 64'd1);
        doOut(0, 31);
        checkOutput("tp_out31", 64'(obs_dout), 64'd1);
        doOut(0, 0);
        checkOutput("tp_empty_out", 64'(obs_dout), 64'd0);
        checkOutput("tp_empty_cnt", 64'(shift_count), 64'd32);

        // Same-cycle autopull refill at threshold 16
        autopull = 1; pull_thresh = 16;
        mov_load = 1; mov_data = 32'hAABBCCDD;
        applyStimulus();
        mov_load = 0;
        fifo_valid = 1; fifo_data = 32'h12345678;
        doOut(1, 16);
        checkOutput("tp_ap_dout", 64'(obs_dout), 64'hCCDD);
        checkOutput("tp_ap_ready", 64'(obs_ready), 64'd1);
        checkOutput("tp_ap_stall", 64'(obs_stall), 64'd0);
        fifo_valid = 0;
        doOut(1, 0);
        checkOutput("tp_ap_refilled", 64'(obs_dout), 64'h12345678);

        // Empty OSR with empty FIFO stalls, then refills on arrival
        out_req = 1; dir = 1; out_count = 4;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("tp_stall_held", 64'(obs_stall), 64'd1);
        end
        fifo_valid = 1; fifo_data = 32'h0000000F;
        applyStimulus();
        checkOutput("tp_stall_refill", 64'(obs_ready), 64'd1);
        fifo_valid = 0;
        applyStimulus();
        checkOutput("tp_retry_dout", 64'(obs_dout), 64'hF);
        out_req = 0;

        // Blocking / non-blocking PULL, and PULL ignored below threshold
        autopull = 0;
        pull_req = 1; pull_block = 1;
        applyStimulus();
        checkOutput("tp_pull_block", 64'(obs_stall), 64'd1);
        pull_block = 0;
        applyStimulus();
        checkOutput("tp_pull_nb_cnt", 64'(shift_count), 64'd0);
        autopull = 1; fifo_valid = 1; fifo_data = 32'h55AA55AA;
        applyStimulus();
        checkOutput("tp_pull_ignored", 64'(obs_ready), 64'd0);
        pull_req = 0; fifo_valid = 0;

        // penable low freezes everything
        penable = 0;
        doOut(1, 8);
        checkOutput("tp_pen_valid", 64'(obs_valid), 64'd0);
        penable = 1;

        // Drain to empty, stall, then reset mid-stall
        doOut(1, 0);
        out_req = 1;
        applyStimulus();
        reset = 1;
        applyStimulus();
        reset = 0; out_req = 0;
        applyStimulus();
        checkOutput("tp_reset_stall_cnt", 64'(shift_count), 64'd32);

        // MOV beats OUT
        mov_load = 1; mov_data = 32'h13579BDF; out_req = 1;
        applyStimulus();
        checkOutput("tp_mov_wins", 64'(obs_valid), 64'd0);
        mov_load = 0; out_req = 0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            penable     = ($urandom_range(0, 7) != 0);
            dir         = 1'($urandom_range(0, 1));
            autopull    = 1'($urandom_range(0, 1));
            pull_thresh = NW'($urandom_range(0, 31));
            out_count   = NW'($urandom_range(0, 31));
            mov_load    = ($urandom_range(0, 9) == 0);
            pull_req    = ($urandom_range(0, 4) == 0);
            pull_block  = 1'($urandom_range(0, 1));
            out_req     = ($urandom_range(0, 3) != 0);
            fifo_valid  = 1'($urandom_range(0, 1));
            mov_data    = $urandom;
            fifo_data   = $urandom;
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/pio_osr_autopull.md
# pio_osr_autopull

Parametrised output shift register (OSR) for the PIO state machine: it holds one TX-FIFO word and shifts 1..WIDTH bits out per OUT instruction, in either direction. It adds what the current fixed 32-bit shifter lacks: a FIFO pop handshake, explicit blocking and non-blocking PULL, MOV load, and autopull with a programmable threshold that can refill in the same cycle as an OUT. It sits between the TX FIFO and the instruction decoder's OUT/PULL/MOV datapath, and drives the stall input of the state-machine sequencer.

## Interface
- WIDTH, 32, register width in bits; must be a power of two and at least 8. Derived: NW = $clog2(WIDTH) for the count fields; CW = NW+1 for the shift count.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- penable  in  1  PIO clock-divider enable; state changes only when this is 1
- dir  in  1  1 = shift right (LSB first), 0 = shift left (MSB first)
- autopull  in  1  enables autopull
- pull_thresh  in  NW  autopull threshold in bits; 0 means WIDTH
- out_req  in  1  OUT instruction this cycle
- out_count  in  NW  bits to shift out; 0 means WIDTH
- pull_req  in  1  PULL instruction this cycle
- pull_block  in  1  PULL blocks when the FIFO is empty
- mov_load  in  1  MOV OSR this cycle
- mov_data  in  WIDTH  data for MOV OSR
- fifo_data  in  WIDTH  TX FIFO head word
- fifo_valid  in  1  TX FIFO not empty
- fifo_ready  out  1  pops the FIFO head this cycle (combinational)
- dout  out  WIDTH  shifted-out bits, right-justified, upper bits zero (combinational)
- out_valid  out  1  dout is valid; OUT completed (combinational)
- stall  out  1  the current instruction must repeat next cycle (combinational)
- shift_count  out  CW  bits consumed: 0 = full, WIDTH = empty (registered)

## Operation
- State: shift_reg[WIDTH-1:0] and count[CW-1:0].
- Reset values: shift_reg = 0 and count = WIDTH. While reset is high, fifo_ready, out_valid, stall and dout are all 0.
- While penable = 0: state is frozen and fifo_ready, out_valid, stall and dout are all 0.
- Definitions: T = (pull_thresh == 0) ? WIDTH : pull_thresh; n = (out_count == 0) ? WIDTH : out_count.
- Request priority when more than one is asserted: mov_load, then pull_req, then out_req. Lower-priority requests are ignored for that cycle.
- mov_load:
  - shift_reg <= mov_data and count <= 0.
  - No FIFO pop and no stall.
- pull_req:
  - If fifo_valid: shift_reg <= fifo_data, count <= 0, fifo_ready = 1.
  - Else if pull_block: stall = 1 and no state change.
  - Else (non-blocking): shift_reg is unchanged and count <= 0.
  - If autopull = 1 and count < T, PULL is a no-op: no pop and no stall.
- out_req when autopull = 1 and count >= T (OSR empty):
  - fifo_valid = 1: refill (shift_reg <= fifo_data, count <= 0, fifo_ready = 1) and stall = 1. The OUT is not performed and completes on the retried cycle.
  - fifo_valid = 0: stall = 1 and no state change.
- out_req otherwise (normal OUT):
  - dir = 1: dout = shift_reg[n-1:0] and shift_reg <= shift_reg >> n.
  - dir = 0: dout = shift_reg[WIDTH-1 -: n], right-justified, and shift_reg <= shift_reg << n.
  - Vacated bits fill with zero. A shift of n = WIDTH leaves shift_reg = 0.
  - count <= min(count + n, WIDTH), computed without overflow.
  - out_valid = 1.
- Same-cycle refill: if a normal OUT makes the new count >= T while autopull = 1 and fifo_valid = 1, then shift_reg <= fifo_data, count <= 0 and fifo_ready = 1. dout still comes from the pre-shift register and there is no stall.
- With autopull = 0, an OUT on an empty OSR still completes and shifts out zeros (count stays at WIDTH).
- No refill happens on idle cycles.

## Timing
- dout, out_valid, stall and fifo_ready are valid in the same cycle as the request; there is no latency.
- shift_reg and shift_count update on the clk edge that ends the request cycle.
- fifo_ready is high for at most one cycle per request, and only when fifo_valid = 1.
- A stalled instruction is held by the sequencer and re-presented each cycle. This block keeps no memory of the stall.
- Reset mid-stall: the next cycle shows count = WIDTH with all strobes at 0.

## Test plan
- Reset with WIDTH = 32: shift_count = 32. PULL with fifo_data = 0xDEADBEEF -> fifo_ready = 1 for 1 cycle, count 0. Then OUT 8 with dir = 1 twice -> dout 0xEF, then 0xBE; count 8, then 16.
- MOV 0x80000001 with dir = 0. OUT 1 -> dout 1. OUT 31 -> dout 0x00000001, count 32. Then OUT with out_count = 0 and autopull = 0 -> dout 0, count stays 32.
- Autopull with T = 16. MOV 0xAABBCCDD, fifo_data = 0x12345678 valid. OUT 16 with dir = 1 -> dout 0xCCDD, fifo_ready = 1, no stall. Next cycle count 0 and OUT 32 -> dout 0x12345678.
- Autopull, count = 32, FIFO empty, OUT held for 3 cycles -> stall = 1 and out_valid = 0 each cycle. fifo_valid rises with 0x0000000F -> stall = 1 with fifo_ready = 1. Next cycle OUT 4 -> dout 0xF, out_valid = 1.
- Blocking PULL on an empty FIFO -> stall = 1 and state held. Non-blocking PULL -> no stall, shift_reg unchanged, count 0. PULL with autopull = 1 and count < T -> no pop and no stall.
- penable = 0 during an OUT -> no change and all strobes 0. Assert reset during a stall -> count = 32 and strobes 0 on the next cycle. mov_load together with out_req -> MOV wins and out_valid = 0.
